// File: rtl/pwm_duty_scheduler_if.sv
// Request bus for the duty scheduler: two duty sources with valid/ready handshakes.
interface pwm_duty_scheduler_if #(
    parameter int CTR_W = 12
);
    logic             req0_valid;
    logic [CTR_W-1:0] req0_duty;
    logic             req0_ready;
    logic             req1_valid;
    logic [CTR_W-1:0] req1_duty;
    logic             req1_ready;

    // Requesters drive valid/duty and observe ready.
    modport master (
        output req0_valid, req0_duty, req1_valid, req1_duty,
        input  req0_ready, req1_ready
    );

    // Scheduler observes valid/duty and drives ready.
    modport slave (
        input  req0_valid, req0_duty, req1_valid, req1_duty,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/pwm_duty_scheduler.sv
// Two-source duty arbiter with frame-synchronous slew limiting and kill override.
// Source 1 has priority; duty_out moves toward target by at most STEP per frame_tick.
module pwm_duty_scheduler #(
    parameter int CTR_W = 12,
    parameter int STEP  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 kill,
    pwm_duty_scheduler_if.slave  req,
    output logic [CTR_W-1:0]     duty_out,
    output logic [CTR_W-1:0]     target,
    output logic                 owner,
    output logic                 busy,
    output logic                 done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RAMP = 2'd1;
    localparam logic [1:0] KILL = 2'd2;

    // Step held one bit wider than the duty so sums never wrap.
    localparam logic [CTR_W:0] STEP_W = (CTR_W+1)'(STEP);

    logic [1:0]       state;
    logic             acc0, acc1;
    logic [CTR_W-1:0] next_target;
    logic             next_owner;
    logic             step_en;
    logic [CTR_W:0]   up_sum;
    logic [CTR_W:0]   down_lim;
    logic [CTR_W-1:0] stepped;
    logic [CTR_W-1:0] next_duty;
    logic             apart;

    // Source 1 always wins; source 0 must hold its request while source 1 is valid.
    assign req.req1_ready = !kill;
    assign req.req0_ready = !kill && !req.req1_valid;
    assign acc1 = req.req1_valid && req.req1_ready;
    assign acc0 = req.req0_valid && req.req0_ready;

    // Accepted request becomes the next target and owner.
    always_comb begin
        next_target = target;
        next_owner  = owner;
        if (acc1) begin
            next_target = req.req1_duty;
            next_owner  = 1'b1;
        end else if (acc0) begin
            next_target = req.req0_duty;
            next_owner  = 1'b0;
        end
    end

    // Slew step toward the current (old) target, clamped so it never overshoots.
    always_comb begin
        up_sum   = {1'b0, duty_out} + STEP_W;
        down_lim = {1'b0, target} + STEP_W;
        if (duty_out < target)
            stepped = (up_sum > {1'b0, target}) ? target : up_sum[CTR_W-1:0];
        else
            stepped = (down_lim >= {1'b0, duty_out}) ? target : duty_out - STEP_W[CTR_W-1:0];
    end

    assign step_en   = frame_tick && (state != KILL) && (duty_out != target);
    assign next_duty = step_en ? stepped : duty_out;
    assign apart     = (next_duty != next_target);

    // State, duty and handshake registers; kill dominates everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty_out <= '0;
            target   <= '0;
            owner    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (kill) begin
            state    <= KILL;
            duty_out <= '0;
            target   <= '0;
            owner    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            duty_out <= next_duty;
            target   <= next_target;
            owner    <= next_owner;
            done     <= step_en && !apart;
            if (state == KILL) begin
                // Leaving kill always passes through IDLE first.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                state <= apart ? RAMP : IDLE;
                busy  <= apart;
            end
        end
    end
endmodule
